// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//
// Command front end for the 16-bit registered ALU. Commands (opcode, A, B)
// from a valid/ready producer go into a small FIFO. They are driven onto the
// ALU bus one at a time. After the ALU's registered latency the result and
// flags are captured and offered, in command order, on a valid/ready
// response port. This block does no arithmetic.
//
// Optional feature: define ALU_CMD_SEQUENCER_DIV0_TRAP_EN to trap divide
// commands (cmd_fun 4'b0011) with cmd_b == 0. A trapped command never
// reaches the ALU. It produces rsp_data=0, rsp_flags=0 and rsp_err=1. With
// the macro undefined, rsp_err is tied to 0.
//
// Parameters:
//   DEPTH   - command FIFO entries (power of 2, >= 2)
//   ALU_LAT - edges from the issue edge to a valid ALU result (>= 1)
//
// Ports:
//   clk, rst                    - rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready         - command handshake
//   cmd_fun/cmd_a/cmd_b         - command opcode and operands
//   alu_a/alu_b/alu_fun         - operand/opcode bus to the ALU
//   alu_out/alu_flags           - ALU result and {Carry,Arith,Logic,CMP,Shift}
//   rsp_valid/rsp_ready         - response handshake
//   rsp_data/rsp_flags/rsp_err  - captured result, flags, trap indication
//   fifo_count                  - FIFO occupancy
//   busy                        - sequencer active or commands pending

module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_fun,
    input  logic [15:0]                cmd_a,
    input  logic [15:0]                cmd_b,
    output logic [15:0]                alu_a,
    output logic [15:0]                alu_b,
    output logic [3:0]                 alu_fun,
    input  logic [15:0]                alu_out,
    input  logic [4:0]                 alu_flags,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [15:0]                rsp_data,
    output logic [4:0]                 rsp_flags,
    output logic                       rsp_err,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(ALU_LAT + 1);
    localparam logic [3:0] FUN_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [35:0]     fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic [3:0]      head_fun;
    logic [15:0]     head_a;
    logic [15:0]     head_b;
    logic            head_trap;

    logic [3:0]      op_fun;
    logic [15:0]     op_a;
    logic [15:0]     op_b;
    logic [LW-1:0]   wait_cnt;
    logic            capture;

    assign fifo_empty = (count == '0);
    assign cmd_ready  = (count != CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign fifo_count = count;
    assign busy       = (state != ST_IDLE) || (count != '0);
    assign rsp_valid  = (state == ST_RESP);
    assign capture    = (state == ST_WAIT) && (wait_cnt == LW'(1));

    assign {head_fun, head_a, head_b} = fifo_mem[rd_ptr];

`ifdef ALU_CMD_SEQUENCER_DIV0_TRAP_EN
    assign head_trap = (head_fun == 4'b0011) && (head_b == 16'h0000);
`else
    assign head_trap = 1'b0;
`endif

    // FIFO storage. The array needs no reset because the pointers and the
    // count decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_fun, cmd_a, cmd_b};
        end
    end

    // FIFO pointers and occupancy. A push and a pop on the same edge leave
    // the count unchanged. DEPTH is a power of two, so the pointers wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Next-state logic. A pop happens from IDLE, or from RESP at the
    // handshake edge, so back-to-back commands skip IDLE. A trapped command
    // goes straight to RESP and never passes through ISSUE.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = head_trap ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (capture) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = head_trap ? ST_RESP : ST_ISSUE;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register, op registers and the latency counter. The counter is
    // loaded on the issue edge. It reaches 1 on the edge where the ALU
    // result is valid, which is the capture edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_fun   <= FUN_IDLE;
            op_a     <= '0;
            op_b     <= '0;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (pop) begin
                op_fun <= head_fun;
                op_a   <= head_a;
                op_b   <= head_b;
            end
            if (state == ST_ISSUE) begin
                wait_cnt <= LW'(ALU_LAT);
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    // Response registers. They hold their value through RESP until the
    // handshake. A trap pop loads them directly with the error response.
`ifdef ALU_CMD_SEQUENCER_DIV0_TRAP_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
            err_q     <= 1'b0;
        end else if (pop && head_trap) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
            err_q     <= 1'b1;
        end else if (capture) begin
            rsp_data  <= alu_out;
            rsp_flags <= alu_flags;
            err_q     <= 1'b0;
        end
    end

    assign rsp_err = err_q;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else if (capture) begin
            rsp_data  <= alu_out;
            rsp_flags <= alu_flags;
        end
    end

    assign rsp_err = 1'b0;
`endif

    // ALU bus. The op is driven from ISSUE entry through the capture edge.
    // Outside that window the bus carries the unused opcode and zero
    // operands, so the ALU produces zero outputs.
    always_comb begin
        alu_fun = FUN_IDLE;
        alu_a   = '0;
        alu_b   = '0;
        if ((state == ST_ISSUE) || (state == ST_WAIT)) begin
            alu_fun = op_fun;
            alu_a   = op_a;
            alu_b   = op_b;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
//
// Directed testbench for alu_cmd_sequencer (DEPTH=4, ALU_LAT=1). A
// behavioural one-cycle registered ALU is attached to the operand bus.
// Inputs are driven and outputs sampled on the falling clock edge.
// Define ALU_CMD_SEQUENCER_DIV0_TRAP_EN on both the DUT and this bench to
// check the divide-by-zero trap.
//
// Ports: none (top-level bench).

module tb_alu_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_fun;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_fun;
    logic [15:0] alu_out;
    logic [4:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [4:0]  rsp_flags;
    logic        rsp_err;
    logic [2:0]  fifo_count;
    logic        busy;

    int total_checks = 0;
    int bad_checks   = 0;

    alu_cmd_sequencer #(
        .DEPTH   (4),
        .ALU_LAT (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_fun    (cmd_fun),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_fun    (alu_fun),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU opcode map. Flags are {Carry, Arith, Logic, CMP, Shift}.
    // Division by zero yields 0 with Arith set. 4'b1111 yields all zeros.
    function automatic logic [20:0] alu_model(input logic [3:0] f,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic [4:0]  fl;
        s  = '0;
        r  = '0;
        fl = '0;
        case (f)
            4'b0000: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; fl = {s[16], 4'b1000}; end
            4'b0001: begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; fl = {s[16], 4'b1000}; end
            4'b0010: begin r = a * b; fl = 5'b01000; end
            4'b0011: begin r = (b == 16'h0000) ? 16'h0000 : a / b; fl = 5'b01000; end
            4'b0100: begin r = a & b;    fl = 5'b00100; end
            4'b0101: begin r = a | b;    fl = 5'b00100; end
            4'b0110: begin r = ~(a & b); fl = 5'b00100; end
            4'b0111: begin r = ~(a | b); fl = 5'b00100; end
            4'b1000: begin r = a ^ b;    fl = 5'b00100; end
            4'b1001: begin r = ~(a ^ b); fl = 5'b00100; end
            default: begin r = '0;       fl = '0;       end
        endcase
        return {fl, r};
    endfunction

    // Registered ALU with a latency of one edge.
    always @(posedge clk) begin
        {alu_flags, alu_out} <= alu_model(alu_fun, alu_a, alu_b);
    end

    // One comparison. It counts every call and reports and counts failures.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_checks++;
        assert (observed === expected)
        else begin
            bad_checks++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offers one command from a falling edge and returns on the falling
    // edge just after the accepting rising edge. The wait is bounded.
    task automatic applyStimulus(input logic [3:0] fun, input logic [15:0] a,
                                 input logic [15:0] b, output bit ok);
        cmd_fun   = fun;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (cmd_ready) ok = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    logic [3:0]  t3_fun   [6] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1000};
    logic [15:0] t3_data  [6] = '{16'd4, 16'd32, 16'd2, 16'd0, 16'd12, 16'd12};
    logic [4:0]  t3_flags [6] = '{5'b01000, 5'b01000, 5'b01000, 5'b00100, 5'b00100, 5'b00100};

    initial begin
        bit ok;
        bit seen;
        bit drop_cmd;
        bit saw_div;
        int got;
        int prev_cyc;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_fun   = 4'h0;
        cmd_a     = 16'h0;
        cmd_b     = 16'h0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: async reset asserted mid-clock while an op is being issued.
        applyStimulus(4'b0000, 16'd8, 16'd4, ok);
        applyStimulus(4'b0001, 16'd5, 16'd3, ok);
        checkOutput("t1_pre_fun", 32'(alu_fun), 32'h0);
        checkOutput("t1_pre_a", 32'(alu_a), 32'd8);
        checkOutput("t1_pre_count", 32'(fifo_count), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t1_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("t1_alu_fun", 32'(alu_fun), 32'hF);
        checkOutput("t1_alu_a", 32'(alu_a), 32'h0);
        checkOutput("t1_alu_b", 32'(alu_b), 32'h0);
        checkOutput("t1_count", 32'(fifo_count), 32'd0);
        checkOutput("t1_busy", 32'(busy), 32'd0);
        checkOutput("t1_rsp_data", 32'(rsp_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Test 2: single add and its latency.
        rsp_ready = 1'b1;
        applyStimulus(4'b0000, 16'd8, 16'd4, ok);
        checkOutput("t2_accept", 32'(ok), 32'd1);
        checkOutput("t2_valid_e1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("t2_valid_e2", 32'(rsp_valid), 32'd0);
        checkOutput("t2_issue_a", 32'(alu_a), 32'd8);
        checkOutput("t2_issue_b", 32'(alu_b), 32'd4);
        @(negedge clk);
        checkOutput("t2_valid_e3", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("t2_valid_e4", 32'(rsp_valid), 32'd1);
        checkOutput("t2_data", 32'(rsp_data), 32'h000C);
        checkOutput("t2_flags", 32'(rsp_flags), 32'h08);
        checkOutput("t2_err", 32'(rsp_err), 32'd0);
        checkOutput("t2_resp_fun", 32'(alu_fun), 32'hF);
        @(negedge clk);
        checkOutput("t2_after_valid", 32'(rsp_valid), 32'd0);
        checkOutput("t2_after_busy", 32'(busy), 32'd0);

        // Test 3: fill the FIFO while responses are blocked, then drain.
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_fun   = t3_fun[i];
            cmd_a     = 16'd8;
            cmd_b     = 16'd4;
            cmd_valid = 1'b1;
            checkOutput($sformatf("t3_ready%0d", i), 32'(cmd_ready), 32'(i < 5));
            if (i < 5) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checkOutput("t3_full_count", 32'(fifo_count), 32'd4);
        checkOutput("t3_full_ready", 32'(cmd_ready), 32'd0);
        checkOutput("t3_first_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        got       = 0;
        prev_cyc  = 0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            drop_cmd = cmd_valid && cmd_ready;
            if (rsp_valid) begin
                checkOutput($sformatf("t3_data%0d", got), 32'(rsp_data), 32'(t3_data[got]));
                checkOutput($sformatf("t3_flags%0d", got), 32'(rsp_flags), 32'(t3_flags[got]));
                if (got > 0) begin
                    checkOutput($sformatf("t3_gap%0d", got), 32'(cyc - prev_cyc), 32'd3);
                end
                prev_cyc = cyc;
                got++;
            end
            @(negedge clk);
            if (drop_cmd) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        checkOutput("t3_rsp_count", 32'(got), 32'd6);
        @(negedge clk);
        checkOutput("t3_idle_busy", 32'(busy), 32'd0);

        // Test 4: NOR response held while the consumer stalls.
        rsp_ready = 1'b0;
        applyStimulus(4'b0111, 16'd8, 16'd4, ok);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        checkOutput("t4_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("t4_hold_valid%0d", i), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("t4_hold_data%0d", i), 32'(rsp_data), 32'hFFF3);
            checkOutput($sformatf("t4_hold_flags%0d", i), 32'(rsp_flags), 32'h04);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("t4_release", 32'(rsp_valid), 32'd0);

        // Test 5: reset during WAIT with a second command queued.
        applyStimulus(4'b0000, 16'd1, 16'd2, ok);
        applyStimulus(4'b0001, 16'd9, 16'd3, ok);
        @(negedge clk);
        checkOutput("t5_wait_busy", 32'(busy), 32'd1);
        checkOutput("t5_wait_count", 32'(fifo_count), 32'd1);
        checkOutput("t5_wait_a", 32'(alu_a), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_count", 32'(fifo_count), 32'd0);
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        checkOutput("t5_rst_fun", 32'(alu_fun), 32'hF);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("t5_no_rsp", 32'(seen), 32'd0);
        checkOutput("t5_idle", 32'(busy), 32'd0);
        applyStimulus(4'b0000, 16'd1, 16'd1, ok);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        checkOutput("t5_new_valid", 32'(rsp_valid), 32'd1);
        checkOutput("t5_new_data", 32'(rsp_data), 32'd2);
        checkOutput("t5_new_flags", 32'(rsp_flags), 32'h08);
        @(negedge clk);

        // Test 6: divide by zero.
        saw_div = 1'b0;
        applyStimulus(4'b0011, 16'd8, 16'd0, ok);
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            if (alu_fun == 4'b0011) saw_div = 1'b1;
            @(negedge clk);
        end
        checkOutput("t6_valid", 32'(rsp_valid), 32'd1);
        checkOutput("t6_data", 32'(rsp_data), 32'h0);
`ifdef ALU_CMD_SEQUENCER_DIV0_TRAP_EN
        checkOutput("t6_err", 32'(rsp_err), 32'd1);
        checkOutput("t6_flags", 32'(rsp_flags), 32'h00);
        checkOutput("t6_fun_seen", 32'(saw_div), 32'd0);
`else
        checkOutput("t6_err", 32'(rsp_err), 32'd0);
        checkOutput("t6_flags", 32'(rsp_flags), 32'h08);
        checkOutput("t6_fun_seen", 32'(saw_div), 32'd1);
`endif
        @(negedge clk);
        checkOutput("t6_done", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
